// File: rtl/icache_nway_burst.sv
// WAYS-way set-associative I-cache; a miss refills the whole line with one AXI INCR burst. Define ICACHE_UNCACHED_EN for uncached kseg1 fetch.
// Hit latency: 1 cycle after RAM read. Miss latency is at least LINE_WORDS+4 cycles. stall is held while AR and R wait on the arbitrater.
module icache_nway_burst #(
  parameter int WAYS         = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] pc_next,
  input  logic [31:0] pcF,
  input  logic        stallF,
  output logic [31:0] inst_rdata,
  output logic        stall,
  output logic        hit,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_WORDS = 2 ** (OFFSET_WIDTH - 2);
  localparam int SETS       = 2 ** INDEX_WIDTH;
  localparam int WSEL_W     = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam int WAY_W      = (WAYS > 2) ? 2 : 1;
  localparam int PLRU_W     = WAYS - 1;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_AR,
    S_R,
    S_WRITE
`ifdef ICACHE_UNCACHED_EN
    , S_UC_DONE
`endif
  } state_t;

  state_t state, state_nx;

  logic [INDEX_WIDTH-1:0]      pc_index, next_index, ram_addr;
  logic [TAG_WIDTH-1:0]        pc_tag;
  logic [WSEL_W-1:0]           word_idx;
  logic [WAYS-1:0]             way_match;
  logic [WAYS-1:0][31:0]       way_word;
  logic [WAYS-1:0][SETS-1:0]   valid;
  logic [SETS-1:0][PLRU_W-1:0] plru;
  line_t                       line_buf;
  logic [WSEL_W-1:0]           beat_cnt;
  logic                        ram_we, plru_we;
  logic [WAY_W-1:0]            victim, hit_way, first_inv, plru_pick, upd_way;
  logic                        any_inv, tag_hit, lookup_hit;
  logic [31:0]                 hit_word;
  logic [WAYS-1:0]             set_valid;
  logic [PLRU_W-1:0]           set_plru, plru_upd;
  logic                        uc_req, uc_q;

  assign pc_index   = INDEX_WIDTH'(pcF >> OFFSET_WIDTH);
  assign next_index = INDEX_WIDTH'(pc_next >> OFFSET_WIDTH);
  assign pc_tag     = pcF[31 -: TAG_WIDTH];
  assign word_idx   = WSEL_W'(pcF >> 2) & WSEL_W'(LINE_WORDS - 1);

  // Advancing pipeline pre-reads the next PC's set; otherwise keep re-reading the current one.
  assign ram_addr = (state == S_LOOKUP && !stall && !stallF) ? next_index : pc_index;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_WIDTH-1:0] tag_ram [SETS];
    line_t                data_ram [SETS];
    logic [TAG_WIDTH-1:0] tag_q;
    line_t                data_q;

    always_ff @(posedge clk) begin
      if (ram_we && victim == WAY_W'(w)) begin
        tag_ram[pc_index]  <= pc_tag;
        data_ram[pc_index] <= line_buf;
      end
      tag_q  <= tag_ram[ram_addr];
      data_q <= data_ram[ram_addr];
    end

    assign way_match[w] = valid[w][pc_index] && (tag_q == pc_tag);
    assign way_word[w]  = data_q[word_idx];
  end

  always_comb begin
    hit_word = '0;
    hit_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        hit_word = way_word[w];
        hit_way  = WAY_W'(w);
      end
    end
  end

  assign tag_hit = |way_match;

`ifdef ICACHE_UNCACHED_EN
  logic [31:0] uc_word;
  assign uc_req = inst_en && (pcF[31:29] == 3'b101);
`else
  assign uc_req = 1'b0;
  assign uc_q   = 1'b0;
`endif

  assign lookup_hit = tag_hit && !uc_req;

  always_comb begin
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) set_valid[w] = valid[w][pc_index];
  end

  always_comb begin
    first_inv = '0;
    any_inv   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        first_inv = WAY_W'(w);
        any_inv   = 1'b1;
      end
    end
  end

  assign set_plru = plru[pc_index];
  assign victim   = any_inv ? first_inv : plru_pick;
  assign upd_way  = (state == S_WRITE) ? victim : hit_way;

  // PLRU bits point at the way to evict next; touching a way points them away from it.
  if (WAYS == 2) begin : g_plru2
    assign plru_pick = set_plru;
    assign plru_upd  = ~upd_way;
  end else begin : g_plru4
    assign plru_pick = set_plru[0] ? {1'b1, set_plru[2]} : {1'b0, set_plru[1]};
    assign plru_upd  = {upd_way[1] ? ~upd_way[0] : set_plru[2],
                        upd_way[1] ? set_plru[1] : ~upd_way[0],
                        ~upd_way[1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      valid    <= '0;
      plru     <= '0;
      beat_cnt <= '0;
`ifdef ICACHE_UNCACHED_EN
      uc_q     <= 1'b0;
      uc_word  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (ram_we) valid[victim][pc_index] <= 1'b1;
      if (plru_we) plru[pc_index] <= plru_upd;
      if (state == S_AR && arready) beat_cnt <= '0;
      else if (state == S_R && rvalid)
        beat_cnt <= (beat_cnt == WSEL_W'(LINE_WORDS - 1)) ? '0 : beat_cnt + 1'b1;
`ifdef ICACHE_UNCACHED_EN
      if (state == S_LOOKUP && state_nx == S_AR) uc_q <= uc_req;
      if (state == S_R && rvalid && uc_q) uc_word <= rdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_R && rvalid) line_buf[beat_cnt] <= rdata;
  end

  always_comb begin
    state_nx   = state;
    stall      = 1'b1;
    hit        = 1'b0;
    inst_rdata = '0;
    arvalid    = 1'b0;
    araddr     = '0;
    arlen      = '0;
    rready     = 1'b0;
    ram_we     = 1'b0;
    plru_we    = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_LOOKUP;
      S_LOOKUP: begin
        hit        = lookup_hit;
        inst_rdata = hit_word;
        stall      = inst_en && !lookup_hit;
        if (inst_en && !lookup_hit) state_nx = S_AR;
        plru_we    = inst_en && lookup_hit && !stallF;
      end
      S_AR: begin
        arvalid = 1'b1;
        araddr  = uc_q ? pcF : {pcF[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        arlen   = uc_q ? 8'd0 : 8'(LINE_WORDS - 1);
        if (arready) state_nx = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          state_nx = S_WRITE;
`ifdef ICACHE_UNCACHED_EN
          if (uc_q) state_nx = S_UC_DONE;
`endif
        end
      end
      S_WRITE: begin
        ram_we   = 1'b1;
        plru_we  = 1'b1;
        state_nx = S_IDLE;
      end
`ifdef ICACHE_UNCACHED_EN
      S_UC_DONE: begin
        stall      = 1'b0;
        inst_rdata = uc_word;
        if (!stallF) state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/icache_nway_burst.md
Name: icache_nway_burst

Overview:
- Parametrised N-way set-associative instruction cache for the fetch stage.
- Lines are multi-word and refilled with one AXI INCR read burst through the arbitrater.
- Victim selection: first invalid way, otherwise tree pseudo-LRU.
- Sits between the PC/F stage and the AXI read arbitrater.

Parameters:
WAYS, 2, associativity; legal values 2 or 4
INDEX_WIDTH, 7, set index bits; sets = 2^INDEX_WIDTH
OFFSET_WIDTH, 4, byte offset bits; LINE_WORDS = 2^(OFFSET_WIDTH-2); range 2..10
(TAG_WIDTH = 32-INDEX_WIDTH-OFFSET_WIDTH, derived, not overridable)

Ports:
clk  in  1  clock, single domain
rst  in  1  reset, asynchronous, active-low
inst_en  in  1  fetch request valid for pcF
pc_next  in  32  next PC; its index addresses RAMs when the pipeline advances
pcF  in  32  current fetch PC
stallF  in  1  F stage held by pipeline
inst_rdata  out  32  fetched instruction
stall  out  1  cache requests F stall
hit  out  1  lookup hit this cycle
araddr  out  32  AR address
arlen  out  8  AR burst length
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rlast  in  1  R last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Storage: per-way tag RAM and line-wide data RAM, synchronous read, 1-cycle latency. Valid bits are a flop array, cleared by rst.
- RAM read address:
  - IDLE: index(pcF).
  - LOOKUP with ~stall & ~stallF: index(pc_next).
  - Otherwise: index(pcF).
- States: IDLE, LOOKUP, AR, R, WRITE.
- IDLE: stall=1; issue RAM read; next state LOOKUP.
- LOOKUP:
  - hit = OR over ways of (valid & tag match).
  - inst_rdata = matching way's word pcF[OFFSET_WIDTH-1:2]; if several ways match, the lowest way index wins.
  - inst_en & miss: stall=1 combinationally, next state AR.
  - Otherwise stall=0.
  - inst_en=0: hit/miss ignored, no state change.
- AR:
  - arvalid=1, araddr = {pcF[31:OFFSET_WIDTH], 0}, arlen = LINE_WORDS-1.
  - arvalid held until arready; araddr/arlen stable while arvalid=1; then R.
- R:
  - rready=1.
  - Each rvalid beat writes line_buf[beat_cnt] and increments beat_cnt (wraps mod LINE_WORDS).
  - rvalid&rlast: next state WRITE.
  - Early rlast: unfilled words keep stale contents. Extra beats overwrite modulo.
- WRITE:
  - stall=1.
  - Write {tag} and line_buf to the victim way; set its valid bit; update PLRU to mark the victim most-recently-used.
  - Next state IDLE (re-read), then LOOKUP hits.
- Miss latency: LOOKUP → AR (≥1) → R (≥LINE_WORDS) → WRITE → IDLE → LOOKUP hit, i.e. ≥ LINE_WORDS+4 cycles.
- Victim: lowest-index invalid way. If all ways are valid:
  - WAYS=2: the single LRU bit.
  - WAYS=4: 3-bit tree; root selects pair, leaf selects way.
- PLRU update: on LOOKUP hit with inst_en & ~stallF; mark hit way MRU.
- Outputs at/after reset: arvalid=0, rready=0, stall=1, hit=0, araddr=0, arlen=0, inst_rdata=0; state=IDLE; valid=0; PLRU=0.
- Reset mid-burst: FSM returns to IDLE immediately; beat_cnt=0. The arbitrater is reset by the same rst, so no transaction is outstanding.
- stallF during AR/R/WRITE has no effect; pcF must be held stable while stall=1.

Optional Feature:
ICACHE_UNCACHED_EN
- Defined: in LOOKUP with inst_en & pcF[31:29]==3'b101 (kseg1), the request is uncached.
  - Forced miss; hit=0.
  - AR: araddr=pcF, arlen=0. R: the single beat is latched.
  - Then state UC_DONE: stall=0, inst_rdata=latched word; held until ~stallF, then IDLE.
  - No RAM write, no valid or PLRU change.
- Undefined: kseg1 addresses are cached like any other; UC_DONE does not exist.

Test Plan:
- Cold miss at pcF=0x80001004, inst_en=1 → AR araddr=0x80001000, arlen=3; 4 beats 0x11,0x22,0x33,0x44 → stall drops ≥8 cycles after miss, hit=1, inst_rdata=0x22.
- Sequential 0x80001000..0x8000100C after fill, stallF=0 → hit=1 each cycle, stall=0, no arvalid.
- Lines 0x80001000, 0x80002000, then re-touch 0x80001000, then 0x80003000 (all set 0) → victim is the 0x80002000 way; re-fetch 0x80001000 hits, 0x80002000 misses.
- arready held low 5 cycles, rvalid gaps between beats → araddr stable, stall=1 throughout, correct line written.
- rst asserted during beat 2 of a burst → arvalid=0, rready=0 immediately; after release, same pcF misses again (valid cleared).
- ICACHE_UNCACHED_EN, pcF=0xBFC00000 fetched twice → two AR bursts, arlen=0 each, hit=0 both times.
